// File: rtl/lsu_arbiter.sv
// lsu_arbiter: shares one single-ported LSU between the core and a DMA port.
// Grants are combinational. A DMA lock gives the DMA exclusive ownership.
// Optional macro LSU_ARB_RR_EN: round-robin on IDLE conflicts (default: core wins).
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_c_* / o_c_*              core request (req/we/addr/wdata/funct3) and gnt/rvalid/rdata
//   i_d_* / o_d_*, i_d_lock    DMA request, response and lock
//   o_lsu_addr .. o_load       drive to the LSU; i_ld_data is the load result one cycle later
//   o_owner                    0 IDLE, 1 CORE, 2 DMA_LOCK
module lsu_arbiter (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_c_req,
  input  logic        i_c_we,
  input  logic [31:0] i_c_addr,
  input  logic [31:0] i_c_wdata,
  input  logic [2:0]  i_c_funct3,
  output logic        o_c_gnt,
  output logic        o_c_rvalid,
  output logic [31:0] o_c_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [2:0]  i_d_funct3,
  input  logic        i_d_lock,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [31:0] o_st_data,
  output logic        o_lsu_wren,
  output logic [2:0]  o_funct3,
  output logic        o_load,
  input  logic [31:0] i_ld_data,
  output logic [1:0]  o_owner
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CORE = 2'd1;
  localparam logic [1:0] ST_LOCK = 2'd2;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       c_gnt;
  logic       d_gnt;
  logic       rv_q;
  logic       tag_q;

`ifdef LSU_ARB_RR_EN
  // ptr_q = 1: DMA wins the next IDLE conflict
  logic ptr_q;
  logic conflict;

  assign conflict = (state_q == ST_IDLE) & i_c_req & i_d_req & ~i_reset;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ptr_q <= 1'b0;
    end else if (conflict) begin
      ptr_q <= c_gnt;
    end
  end
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (d_gnt && i_d_lock) state_d = ST_LOCK;
      ST_LOCK: if (d_gnt && !i_d_lock) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    c_gnt   = 1'b0;
    d_gnt   = 1'b0;
    o_owner = ST_IDLE;
    if (!i_reset) begin
      if (state_q == ST_LOCK) begin
        d_gnt   = i_d_req;
        o_owner = ST_LOCK;
      end else begin
        if (i_c_req && i_d_req) begin
`ifdef LSU_ARB_RR_EN
          c_gnt = ~ptr_q;
          d_gnt = ptr_q;
`else
          c_gnt = 1'b1;
`endif
        end else begin
          c_gnt = i_c_req;
          d_gnt = i_d_req;
        end
        if (c_gnt) o_owner = ST_CORE;
      end
    end
  end

  assign o_c_gnt = c_gnt;
  assign o_d_gnt = d_gnt;

  always_comb begin
    o_lsu_addr = '0;
    o_st_data  = '0;
    o_funct3   = '0;
    o_lsu_wren = 1'b0;
    o_load     = 1'b0;
    unique case (1'b1)
      c_gnt: begin
        o_lsu_addr = i_c_addr;
        o_st_data  = i_c_wdata;
        o_funct3   = i_c_funct3;
        o_lsu_wren = i_c_we;
        o_load     = ~i_c_we;
      end
      d_gnt: begin
        o_lsu_addr = i_d_addr;
        o_st_data  = i_d_wdata;
        o_funct3   = i_d_funct3;
        o_lsu_wren = i_d_we;
        o_load     = ~i_d_we;
      end
      default: ;
    endcase
  end

  // tag_q = 1: the outstanding load belongs to the DMA
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rv_q  <= 1'b0;
      tag_q <= 1'b0;
    end else begin
      rv_q  <= o_load;
      tag_q <= d_gnt;
    end
  end

  // reset in the response cycle swallows the pending rvalid
  assign o_c_rvalid = rv_q & ~tag_q & ~i_reset;
  assign o_d_rvalid = rv_q & tag_q & ~i_reset;
  assign o_c_rdata  = o_c_rvalid ? i_ld_data : '0;
  assign o_d_rdata  = o_d_rvalid ? i_ld_data : '0;

endmodule

// File: doc/lsu_arbiter.md
LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 Parameter: none; all widths fixed (address 32, data 32, funct3 3).
REQ-002 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 i_reset  in  1  synchronous, active-high reset.
REQ-004 i_c_req / i_c_we / i_c_addr / i_c_wdata / i_c_funct3  in  1/1/32/32/3  core port request: valid, store-not-load, byte address, store data, size/sign code.
REQ-005 o_c_gnt  out  1  core request accepted this cycle; o_c_rvalid  out  1  core load data valid; o_c_rdata  out  32  core load data.
REQ-006 i_d_req / i_d_we / i_d_addr / i_d_wdata / i_d_funct3  in  1/1/32/32/3  DMA port request, same meaning as core.
REQ-007 i_d_lock  in  1  DMA requests exclusive LSU ownership starting with the current granted access.
REQ-008 o_d_gnt / o_d_rvalid / o_d_rdata  out  1/1/32  DMA grant, load valid, load data.
REQ-009 o_lsu_addr / o_st_data / o_lsu_wren / o_funct3 / o_load  out  32/32/1/3/1  single LSU port drive.
REQ-010 i_ld_data  in  32  LSU load result, valid one cycle after the load is presented.
REQ-011 o_owner  out  2  state encoding: 0 IDLE, 1 CORE, 2 DMA_LOCK.

Function
REQ-012 Grant is combinational in the request cycle; an access is accepted when req and gnt are both high.
REQ-013 At most one of o_c_gnt, o_d_gnt is high in any cycle.
REQ-014 The granted port's addr/wdata/funct3 drive the LSU; o_lsu_wren = gnt & we; o_load = gnt & ~we.
REQ-015 No grant: o_lsu_wren = 0, o_load = 0, o_lsu_addr = 0, o_st_data = 0, o_funct3 = 0.
REQ-016 Load latency is exactly 1 cycle: an accepted load in cycle N raises that port's rvalid in cycle N+1 with rdata = i_ld_data.
REQ-017 A one-bit registered response tag routes rvalid; the non-owning port's rvalid is 0 and its rdata is 0.
REQ-018 Stores produce no rvalid.
REQ-019 State IDLE: no lock held; arbitrate per REQ-023/024.
REQ-020 IDLE -> DMA_LOCK when the DMA is granted with i_d_lock = 1; DMA_LOCK persists while the DMA holds the lock.
REQ-021 In DMA_LOCK: core is never granted; DMA is granted whenever i_d_req = 1.
REQ-022 DMA_LOCK -> IDLE after the first accepted DMA access with i_d_lock = 0 (that access completes normally); a cycle with i_d_req = 0 does not release the lock.
REQ-023 Conflict (both req in IDLE), LSU_ARB_RR_EN undefined: core wins.
REQ-024 Only one requester in IDLE: that requester is granted immediately.
REQ-025 o_owner = CORE (1) for any IDLE-state cycle where the core is granted; otherwise reports IDLE or DMA_LOCK.
REQ-026 Back-to-back accesses every cycle are supported with no bubble; a load at N and a store at N+1 to the same address both complete in order.

Reset
REQ-027 During reset: all gnt = 0, all rvalid = 0, all rdata = 0, all LSU drive outputs = 0, o_owner = 0.
REQ-028 Reset clears state to IDLE, lock released, response tag cleared, round-robin pointer = core.
REQ-029 Reset asserted in the cycle after an accepted load suppresses that rvalid.
REQ-030 First grant possible in the first cycle after i_reset deasserts.

Configuration
REQ-031 Macro LSU_ARB_RR_EN: when defined, IDLE conflicts use round-robin -- the port not granted on the last conflict wins; pointer updates only on conflict cycles.
REQ-032 Without LSU_ARB_RR_EN: fixed priority, core always wins in IDLE; no pointer register exists.
REQ-033 Lock behaviour (REQ-020..022) is identical in both builds.

Verification
REQ-034 Core load addr 0x0000_0010 alone, LSU returns 0xDEAD_BEEF next cycle -> o_c_gnt = 1 at N, o_c_rvalid = 1 and o_c_rdata = 0xDEAD_BEEF at N+1, o_d_rvalid = 0.
REQ-035 Both request for 4 cycles, no lock -> default build: core granted 4 times, DMA 0; LSU_ARB_RR_EN build: grants alternate C, D, C, D.
REQ-036 DMA store addr 0x1000_0000 data 0x5A with i_d_lock = 1, then core req held while DMA idles 2 cycles, then DMA load with lock = 0 -> core blocked through the DMA load cycle, granted in the following cycle, o_owner = 2 throughout the lock.
REQ-037 Accepted DMA load at N, i_reset = 1 at N+1 -> o_d_rvalid = 0 at N+1, o_owner = 0, all LSU drives 0.
REQ-038 Core store 0x0000_0020 = 0x1122_3344 at N, core load same address at N+1 -> o_lsu_wren = 1 at N, o_load = 1 at N+1, o_c_rvalid at N+2 with 0x1122_3344.
REQ-039 No requests -> o_lsu_wren = 0, o_load = 0, o_lsu_addr = 0 every cycle.
